// File: rtl/sw_debouncer_pkg.sv
// Shared constants for the slide-switch debouncer: default sizes and the
// per-bit FSM state encoding.
package sw_pkg;

  localparam int N_SW_DEFAULT = 3;
  localparam int DEBOUNCE_SIM = 4;
  localparam int DEBOUNCE_HW  = 500000;

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  // $clog2 of the cycle count, floored at 1 so a 2-sample debounce still gets a bit
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sw_debouncer_debounce_bit.sv
// Single-bit stability filter: q follows d_sync only after DEBOUNCE_CYCLES
// consecutive mismatching samples; any earlier return to q discards the count.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_HW,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_sync,
  output logic q,
  output logic pend,
  output logic upd
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          upd_q, upd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    upd_d   = 1'b0;
    if (state_q == ST_STABLE) begin
      if (d_sync != q_q) begin
        cnt_d   = CW'(1);
        state_d = ST_PENDING;
      end else begin
        cnt_d = '0;
      end
    end else begin
      if (d_sync == q_q) begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end else if (cnt_q == CNT_LAST) begin
        // the mismatching sample that completes the run commits the new level
        q_d     = d_sync;
        cnt_d   = '0;
        state_d = ST_STABLE;
        upd_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      upd_q   <= upd_d;
    end
  end

  assign q    = q_q;
  assign pend = (state_q == ST_PENDING);
  assign upd  = upd_q;

endmodule

// File: rtl/sw_debouncer.sv
// Slide-switch conditioning: 2-FF synchroniser per bit followed by a per-bit
// debounce filter; emits a one-cycle strobe whenever the debounced value moves.
module sw_debouncer
  import sw_pkg::*;
#(
  parameter int              N_SW            = N_SW_DEFAULT,
  parameter int              DEBOUNCE_CYCLES = DEBOUNCE_HW,
  parameter logic [N_SW-1:0] SW_RESET_VAL    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw,
  output logic            sw_changed,
  output logic            busy
);

  logic [N_SW-1:0] s1_q, s1_d;
  logic [N_SW-1:0] s2_q, s2_d;
  logic [N_SW-1:0] upd;
  logic [N_SW-1:0] pend;

  always_comb begin
    s1_d = sw_raw;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= SW_RESET_VAL;
      s2_q <= SW_RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (SW_RESET_VAL[i])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .d_sync (s2_q[i]),
      .q      (sw[i]),
      .pend   (pend[i]),
      .upd    (upd[i])
    );
  end

  // both terms are ORs of flop outputs, so they only move on clock edges
  assign sw_changed = |upd;
  assign busy       = |pend;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with a 4-sample debounce; each scenario is a
// per-cycle table of raw input and hand-derived sw / strobe / busy values.
module tb_sw_debouncer;
  import sw_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] sw_raw;
  logic [2:0] sw;
  logic       sw_changed;
  logic       busy;

  int checks = 0;
  int errors = 0;

  sw_debouncer #(
    .N_SW            (3),
    .DEBOUNCE_CYCLES (DEBOUNCE_SIM),
    .SW_RESET_VAL    (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .sw         (sw),
    .sw_changed (sw_changed),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sw"},   32'(sw),         32'(3'b000));
    chk({tag, "_chg"},  32'(sw_changed), 32'(1'b0));
    chk({tag, "_busy"}, 32'(busy),       32'(1'b0));
  endtask

  // Row j: raw is applied before rising edge j, outputs are sampled on the
  // following falling edge.
  task automatic run_vec(input string tag, input logic [35:0] raw_p,
                         input logic [35:0] sw_p, input logic [11:0] chg_m,
                         input logic [11:0] busy_m);
    for (int j = 0; j < 12; j++) begin
      sw_raw = raw_p[3*j +: 3];
      step();
      chk($sformatf("%s_sw_%0d", tag, j),   32'(sw),         32'(sw_p[3*j +: 3]));
      chk($sformatf("%s_chg_%0d", tag, j),  32'(sw_changed), 32'(chg_m[j]));
      chk($sformatf("%s_busy_%0d", tag, j), 32'(busy),       32'(busy_m[j]));
    end
  endtask

  task automatic do_reset(input logic [2:0] raw);
    sw_raw = raw;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    // 1: reset with switches already at 101, then full latency after release
    reset  = 1'b1;
    sw_raw = 3'b101;
    #3;
    chk_idle("rst_t0");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("rst_hold_%0d", i));
    end
    reset = 1'b0;
    run_vec("rel", {12{3'b101}}, {{7{3'b101}}, {5{3'b000}}}, 12'h020, 12'h01C);

    // 2: single bit 0->1 held
    do_reset(3'b000);
    chk_idle("t2_pre");
    run_vec("single", {12{3'b001}}, {{7{3'b001}}, {5{3'b000}}}, 12'h020, 12'h01C);

    // 3: 3-cycle glitch on bit 1 is one sample short of committing
    do_reset(3'b000);
    run_vec("glitch", {{9{3'b000}}, {3{3'b010}}}, 36'h0, 12'h000, 12'h01C);

    // 4: bounce on bit 2, final settle before edge 4 commits at edge 9
    do_reset(3'b000);
    run_vec("bounce",
            {{8{3'b100}}, 3'b000, 3'b100, 3'b000, 3'b100},
            {{3{3'b100}}, {9{3'b000}}}, 12'h200, 12'h1D4);

    // 5a: two bits together -> one update edge, one strobe
    do_reset(3'b000);
    run_vec("simul", {12{3'b110}}, {{7{3'b110}}, {5{3'b000}}}, 12'h020, 12'h01C);

    // 5b: staggered by one cycle -> 010 then 110, strobe on both edges
    do_reset(3'b000);
    run_vec("stagger", {{11{3'b110}}, 3'b010},
            {{6{3'b110}}, 3'b010, {5{3'b000}}}, 12'h060, 12'h03C);

    // 6: asynchronous reset while a change is pending
    do_reset(3'b000);
    sw_raw = 3'b001;
    for (int i = 0; i < 4; i++) step();
    chk("midrst_busy_pre", 32'(busy), 32'(1'b1));
    #3;
    reset = 1'b1;
    #2;
    chk_idle("midrst_async");
    step();
    step();
    chk_idle("midrst_hold");
    reset = 1'b0;
    run_vec("restart", {12{3'b001}}, {{7{3'b001}}, {5{3'b000}}}, 12'h020, 12'h01C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
